// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: opcode encoding used by the ALU and its clients,
// and the tag record that follows each issued operation through the ALU latency.
package myTypes;

  // Tag index is sized for the largest supported requester count (8).
  localparam int TAG_IDXW = 3;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLL = 4'd5,
    OP_SRL = 4'd6,
    OP_SLT = 4'd7
  } alu_op_e;

  typedef struct packed {
    logic                valid;
    logic [TAG_IDXW-1:0] idx;
  } tag_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, ALU and response bundle between requesters and the ALU arbiter.
// The arbiter uses the slave view; requesters, ALU and responders sit on the master view.
interface alu_arbiter_if #(
  parameter int NBITS = 8,
  parameter int NREQ  = 2,
  parameter int OPW   = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*OPW-1:0]   req_op;
  logic [NREQ*NBITS-1:0] req_a;
  logic [NREQ*NBITS-1:0] req_b;
  logic [NREQ-1:0]       kill;
  logic [OPW-1:0]        alu_op;
  logic [NBITS-1:0]      alu_a;
  logic [NBITS-1:0]      alu_b;
  logic [NBITS-1:0]      alu_res;
  logic [NREQ-1:0]       rsp_valid;
  logic [NBITS-1:0]      rsp_data;
  logic                  busy;

  modport master (
    output req_valid, req_op, req_a, req_b, kill, alu_res,
    input  req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, kill, alu_res,
    output req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the pointer upward with wrap, grants at most one
// requester per cycle and moves the pointer just past the winner.
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_en,
  output logic [NREQ-1:0] o_grant,
  output logic [IDXW-1:0] o_idx,
  output logic            o_found
);
  logic [IDXW-1:0] r_ptr;
  logic [IDXW:0]   w_sum;
  logic [IDXW-1:0] w_cand;

  // NOTE: combinational blocks use blocking '=' and give every output a default
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    o_grant = '0;
    o_idx   = r_ptr;
    o_found = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IDXW+1)'(k);
      if (w_sum >= (IDXW+1)'(NREQ)) w_sum = w_sum - (IDXW+1)'(NREQ);
      w_cand = w_sum[IDXW-1:0];
      if (i_en && !o_found && i_req[w_cand]) begin
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
        o_found         = 1'b1;
      end
    end
  end

  // NOTE: clocked state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr <= '0;
    end else if (o_found) begin
      r_ptr <= (o_idx == IDXW'(NREQ - 1)) ? '0 : o_idx + 1'b1;
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters: round-robin issue into registered operands,
// tag pipe matching the ALU latency, and a one-hot registered response with per-requester kill.
module alu_arbiter
  import myTypes::*;
#(
  parameter int NBITS   = 8,
  parameter int NREQ    = 2,
  parameter int OPW     = 4,
  parameter int ALU_LAT = 0
) (
  input logic          CLK,
  input logic          RST,
  alu_arbiter_if.slave bus
);
  localparam int IDXW  = $clog2(NREQ);
  localparam int DEPTH = 1 + ALU_LAT;

  logic [NREQ-1:0]  w_grant;
  logic [IDXW-1:0]  w_gidx;
  logic             w_gvalid;
  logic [OPW-1:0]   w_sel_op;
  logic [NBITS-1:0] w_sel_a;
  logic [NBITS-1:0] w_sel_b;
  logic             w_cap;
  logic [NREQ-1:0]  w_cap_oh;
  logic             w_busy;

  logic [OPW-1:0]   r_alu_op;
  logic [NBITS-1:0] r_alu_a;
  logic [NBITS-1:0] r_alu_b;
  logic [NBITS-1:0] r_rsp_data;
  logic [NREQ-1:0]  r_rsp_valid;
  tag_t [DEPTH-1:0] r_tag;

  function automatic logic tag_killed(input tag_t t, input logic [NREQ-1:0] k);
    tag_killed = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (t.valid && k[i] && (t.idx == TAG_IDXW'(i))) tag_killed = 1'b1;
  endfunction

  // No grant is issued while reset is held.
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .CLK     (CLK),
    .RST     (RST),
    .i_req   (bus.req_valid),
    .i_en    (~RST),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_found (w_gvalid)
  );

  always_comb begin
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_op = bus.req_op[i*OPW +: OPW];
        w_sel_a  = bus.req_a[i*NBITS +: NBITS];
        w_sel_b  = bus.req_b[i*NBITS +: NBITS];
      end
    end
  end

  // A kill arriving in the capture cycle still suppresses the response.
  always_comb begin
    w_cap    = r_tag[DEPTH-1].valid && !tag_killed(r_tag[DEPTH-1], bus.kill);
    w_cap_oh = '0;
    for (int i = 0; i < NREQ; i++)
      w_cap_oh[i] = w_cap && (r_tag[DEPTH-1].idx == TAG_IDXW'(i));
    w_busy = |r_rsp_valid;
    for (int k = 0; k < DEPTH; k++)
      w_busy = w_busy | r_tag[k].valid;
  end

  // NOTE: the tag pipe is reset as a whole because its valid bits decide which
  // responses exist; a stale valid after reset would emit a phantom result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_alu_op    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_tag       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      if (w_gvalid) begin
        r_alu_op <= w_sel_op;
        r_alu_a  <= w_sel_a;
        r_alu_b  <= w_sel_b;
      end
      r_tag[0].valid <= w_gvalid;
      r_tag[0].idx   <= TAG_IDXW'(w_gidx);
      for (int k = 1; k < DEPTH; k++) begin
        r_tag[k].valid <= r_tag[k-1].valid && !tag_killed(r_tag[k-1], bus.kill);
        r_tag[k].idx   <= r_tag[k-1].idx;
      end
      r_rsp_valid <= w_cap_oh;
      if (w_cap) r_rsp_data <= bus.alu_res;
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.alu_op    = r_alu_op;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.busy      = w_busy;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: three instances (2 req/comb ALU, 4 req/comb ALU,
// 2 req/2-stage ALU) driven from a vector table plus hand-written multi-cycle sequences.
module tb_alu_arbiter;
  import myTypes::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    int unsigned req;
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  res;
  } vec_t;

  alu_arbiter_if #(.NBITS(8), .NREQ(2), .OPW(4)) if0 ();
  alu_arbiter_if #(.NBITS(8), .NREQ(4), .OPW(4)) if1 ();
  alu_arbiter_if #(.NBITS(8), .NREQ(2), .OPW(4)) if2 ();

  alu_arbiter #(.NBITS(8), .NREQ(2), .OPW(4), .ALU_LAT(0)) u_d0 (.CLK(CLK), .RST(RST), .bus(if0));
  alu_arbiter #(.NBITS(8), .NREQ(4), .OPW(4), .ALU_LAT(0)) u_d1 (.CLK(CLK), .RST(RST), .bus(if1));
  alu_arbiter #(.NBITS(8), .NREQ(2), .OPW(4), .ALU_LAT(2)) u_d2 (.CLK(CLK), .RST(RST), .bus(if2));

  always #5 CLK = ~CLK;

  // Behavioural stand-in for the shared ALU.
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  alu_f = a + b;
      OP_SUB:  alu_f = a - b;
      OP_AND:  alu_f = a & b;
      OP_OR:   alu_f = a | b;
      OP_XOR:  alu_f = a ^ b;
      OP_SLL:  alu_f = a << b[2:0];
      OP_SRL:  alu_f = a >> b[2:0];
      OP_SLT:  alu_f = {7'b0, $signed(a) < $signed(b)};
      default: alu_f = 8'h00;
    endcase
  endfunction

  logic [7:0] r_p1, r_p2;
  assign if0.alu_res = alu_f(if0.alu_op, if0.alu_a, if0.alu_b);
  assign if1.alu_res = alu_f(if1.alu_op, if1.alu_a, if1.alu_b);
  always @(posedge CLK) begin
    r_p1 <= alu_f(if2.alu_op, if2.alu_a, if2.alu_b);
    r_p2 <= r_p1;
  end
  assign if2.alu_res = r_p2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [10];
    int         cnt  [4];
    logic [1:0] oh;

    vecs[0] = '{0, OP_ADD, 8'h05, 8'h03, 8'h08};
    vecs[1] = '{1, OP_SUB, 8'h10, 8'h01, 8'h0F};
    vecs[2] = '{0, OP_AND, 8'hF0, 8'h3C, 8'h30};
    vecs[3] = '{1, OP_OR,  8'hF0, 8'h0F, 8'hFF};
    vecs[4] = '{0, OP_XOR, 8'hAA, 8'hFF, 8'h55};
    vecs[5] = '{1, OP_SLL, 8'h81, 8'h01, 8'h02};
    vecs[6] = '{0, OP_SRL, 8'h80, 8'h03, 8'h10};
    vecs[7] = '{1, OP_SLT, 8'h80, 8'h01, 8'h01};
    vecs[8] = '{0, OP_ADD, 8'hFF, 8'h01, 8'h00};
    vecs[9] = '{1, OP_SLT, 8'h01, 8'h80, 8'h00};

    if0.req_valid = '0; if0.req_op = '0; if0.req_a = '0; if0.req_b = '0; if0.kill = '0;
    if1.req_valid = '0; if1.req_op = '0; if1.req_a = '0; if1.req_b = '0; if1.kill = '0;
    if2.req_valid = '0; if2.req_op = '0; if2.req_a = '0; if2.req_b = '0; if2.kill = '0;

    repeat (3) @(posedge CLK);
    step();
    RST = 1'b0;
    #1;
    check("reset alu_op",    32'(if0.alu_op),    32'h0);
    check("reset alu_a",     32'(if0.alu_a),     32'h0);
    check("reset rsp_valid", 32'(if0.rsp_valid), 32'h0);
    check("reset rsp_data",  32'(if0.rsp_data),  32'h0);
    check("reset busy",      32'(if0.busy),      32'h0);
    check("reset ready",     32'(if0.req_ready), 32'h0);

    // Table: single isolated issues, latency 2, busy in the two following cycles.
    for (int i = 0; i < 10; i++) begin
      oh = 2'(1 << vecs[i].req);
      step();
      if0.req_valid = oh;
      if0.req_op[vecs[i].req*4 +: 4] = vecs[i].op;
      if0.req_a[vecs[i].req*8 +: 8]  = vecs[i].a;
      if0.req_b[vecs[i].req*8 +: 8]  = vecs[i].b;
      #1;
      check($sformatf("v%0d ready", i), 32'(if0.req_ready), 32'(oh));
      step();
      if0.req_valid = '0;
      #1;
      check($sformatf("v%0d alu_op", i), 32'(if0.alu_op), 32'(vecs[i].op));
      check($sformatf("v%0d alu_a", i),  32'(if0.alu_a),  32'(vecs[i].a));
      check($sformatf("v%0d alu_b", i),  32'(if0.alu_b),  32'(vecs[i].b));
      check($sformatf("v%0d busy1", i),  32'(if0.busy),   32'h1);
      step();
      check($sformatf("v%0d rsp_valid", i), 32'(if0.rsp_valid), 32'(oh));
      check($sformatf("v%0d rsp_data", i),  32'(if0.rsp_data),  32'(vecs[i].res));
      check($sformatf("v%0d busy2", i),     32'(if0.busy),      32'h1);
      step();
      check($sformatf("v%0d rsp_idle", i),  32'(if0.rsp_valid), 32'h0);
      check($sformatf("v%0d data_hold", i), 32'(if0.rsp_data),  32'(vecs[i].res));
      check($sformatf("v%0d busy_idle", i), 32'(if0.busy),      32'h0);
    end

    // Round-robin alternation, both requesting for 6 cycles.
    if0.req_op = {OP_SUB, OP_ADD};
    if0.req_a  = {8'h10, 8'h20};
    if0.req_b  = {8'h01, 8'h01};
    for (int c = 0; c < 8; c++) begin
      step();
      if0.req_valid = (c < 6) ? 2'b11 : 2'b00;
      #1;
      if (c < 6) check($sformatf("rr grant c%0d", c), 32'(if0.req_ready), ((c % 2) == 0) ? 32'h1 : 32'h2);
      if (c >= 2) begin
        check($sformatf("rr rsp_valid c%0d", c), 32'(if0.rsp_valid), (((c - 2) % 2) == 0) ? 32'h1 : 32'h2);
        check($sformatf("rr rsp_data c%0d", c),  32'(if0.rsp_data),  (((c - 2) % 2) == 0) ? 32'h21 : 32'h0F);
      end
    end
    step();
    check("rr drained rsp", 32'(if0.rsp_valid), 32'h0);
    check("rr drained busy", 32'(if0.busy), 32'h0);

    // Kill of requester 1 in flight; requester 0 unaffected; kill does not block a new grant.
    if0.req_op = {OP_ADD, OP_XOR};
    if0.req_a  = {8'h77, 8'h3C};
    if0.req_b  = {8'h11, 8'h0F};
    step(); if0.req_valid = 2'b10; #1;
    check("kill c1 ready", 32'(if0.req_ready), 32'h2);
    step(); if0.req_valid = 2'b01; if0.kill = 2'b10; #1;
    check("kill c2 ready", 32'(if0.req_ready), 32'h1);
    step(); if0.req_valid = 2'b00; if0.kill = 2'b00; #1;
    check("kill c3 no rsp", 32'(if0.rsp_valid), 32'h0);
    check("kill c3 data hold", 32'(if0.rsp_data), 32'h0F);
    check("kill c3 busy", 32'(if0.busy), 32'h1);
    step();
    check("kill c4 rsp0", 32'(if0.rsp_valid), 32'h1);
    check("kill c4 data", 32'(if0.rsp_data), 32'h33);
    step(); if0.req_valid = 2'b10; if0.kill = 2'b10; #1;
    check("kill+grant ready", 32'(if0.req_ready), 32'h2);
    step(); if0.req_valid = 2'b00; if0.kill = 2'b00; #1;
    step();
    check("kill+grant rsp1", 32'(if0.rsp_valid), 32'h2);
    check("kill+grant data", 32'(if0.rsp_data), 32'h88);
    step();
    check("kill idle busy", 32'(if0.busy), 32'h0);

    // Reset in the cycle after the third back-to-back grant.
    if0.req_op = {OP_OR, OP_AND};
    if0.req_a  = {8'hA0, 8'hFF};
    if0.req_b  = {8'h05, 8'h0F};
    step(); if0.req_valid = 2'b11; #1;
    check("rst g1", 32'(if0.req_ready), 32'h1);
    step();
    check("rst g2", 32'(if0.req_ready), 32'h2);
    step();
    check("rst g3", 32'(if0.req_ready), 32'h1);
    step(); if0.req_valid = 2'b00; RST = 1'b1; #1;
    step(); RST = 1'b0; #1;
    check("rst alu_op",    32'(if0.alu_op),    32'h0);
    check("rst alu_a",     32'(if0.alu_a),     32'h0);
    check("rst alu_b",     32'(if0.alu_b),     32'h0);
    check("rst rsp_valid", 32'(if0.rsp_valid), 32'h0);
    check("rst rsp_data",  32'(if0.rsp_data),  32'h0);
    check("rst busy",      32'(if0.busy),      32'h0);
    for (int c = 0; c < 2; c++) begin
      step();
      check($sformatf("rst quiet c%0d", c), 32'(if0.rsp_valid), 32'h0);
    end
    step(); if0.req_valid = 2'b11; #1;
    check("rst first grant", 32'(if0.req_ready), 32'h1);
    step(); if0.req_valid = 2'b00; #1;
    step();
    check("rst after rsp", 32'(if0.rsp_valid), 32'h1);
    check("rst after data", 32'(if0.rsp_data), 32'h0F);

    // Four requesters: fairness, pointer wrap, no lost responses.
    if1.req_op = {OP_ADD, OP_ADD, OP_ADD, OP_ADD};
    if1.req_a  = {8'h30, 8'h20, 8'h10, 8'h00};
    if1.req_b  = {8'h03, 8'h02, 8'h01, 8'h00};
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if1.req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) check($sformatf("fair grant c%0d", c), 32'(if1.req_ready), 32'(1 << (c % 4)));
      if (c >= 2) begin
        check($sformatf("fair rsp_valid c%0d", c), 32'(if1.rsp_valid), 32'(1 << ((c - 2) % 4)));
        check($sformatf("fair rsp_data c%0d", c),  32'(if1.rsp_data),  32'(((c - 2) % 4) * 17));
      end
      for (int i = 0; i < 4; i++) if (if1.rsp_valid[i]) cnt[i]++;
    end
    for (int i = 0; i < 4; i++) check($sformatf("fair count r%0d", i), 32'(cnt[i]), 32'h2);

    // Single requester held continuously is granted every cycle.
    for (int c = 0; c < 4; c++) begin
      step();
      if1.req_valid = 4'b0100;
      #1;
      check($sformatf("solo grant c%0d", c), 32'(if1.req_ready), 32'h4);
      if (c >= 2) check($sformatf("solo rsp c%0d", c), 32'(if1.rsp_valid), 32'h4);
    end
    step(); if1.req_valid = 4'h0; #1;
    repeat (3) step();
    check("solo drained busy", 32'(if1.busy), 32'h0);

    // Two-stage ALU: latency 4, back-to-back issue gives back-to-back responses.
    if2.req_op = {OP_ADD, OP_XOR};
    if2.req_a  = {8'h01, 8'hF0};
    if2.req_b  = {8'h02, 8'h0F};
    step(); if2.req_valid = 2'b01; #1;
    check("pipe issue", 32'(if2.req_ready), 32'h1);
    for (int c = 1; c < 4; c++) begin
      step(); if2.req_valid = 2'b00; #1;
      check($sformatf("pipe wait c%0d", c), 32'(if2.rsp_valid), 32'h0);
      check($sformatf("pipe busy c%0d", c), 32'(if2.busy), 32'h1);
    end
    step();
    check("pipe rsp", 32'(if2.rsp_valid), 32'h1);
    check("pipe data", 32'(if2.rsp_data), 32'hFF);
    if2.req_op = {OP_ADD, OP_SUB};
    if2.req_a  = {8'h01, 8'h09};
    if2.req_b  = {8'h02, 8'h04};
    step(); if2.req_valid = 2'b11; #1;
    check("pipe b2b g1", 32'(if2.req_ready), 32'h2);
    step();
    check("pipe b2b g2", 32'(if2.req_ready), 32'h1);
    step(); if2.req_valid = 2'b00; #1;
    check("pipe b2b wait", 32'(if2.rsp_valid), 32'h0);
    step();
    step();
    check("pipe b2b rsp1", 32'(if2.rsp_valid), 32'h2);
    check("pipe b2b data1", 32'(if2.rsp_data), 32'h03);
    step();
    check("pipe b2b rsp2", 32'(if2.rsp_valid), 32'h1);
    check("pipe b2b data2", 32'(if2.rsp_data), 32'h05);
    step();
    check("pipe b2b idle", 32'(if2.rsp_valid), 32'h0);
    check("pipe b2b busy", 32'(if2.busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
